// File: rtl/lru_tick_tracker.sv
// Per-line access timestamps for LRU victim selection, with a per-set
// rank-compression sweep that rebases ticks when the access counter saturates.

`ifndef CACHE_S
`define CACHE_S 4
`endif
`ifndef CACHE_E
`define CACHE_E 4
`endif

module lru_tick_tracker #(
  parameter int SET_COUNT    = `CACHE_S,
  parameter int SET_SIZE     = `CACHE_E,
  parameter int TICK_WIDTH   = 32,
  parameter int _INDEX_WIDTH = $clog2(SET_COUNT),
  parameter int _WAY_WIDTH   = $clog2(SET_SIZE)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [_INDEX_WIDTH-1:0] req_set,
  input  logic [_WAY_WIDTH-1:0]   req_way,
  input  logic                    req_invalidate,
  input  logic [_INDEX_WIDTH-1:0] query_set,
  output logic [TICK_WIDTH-1:0]   tick [1:SET_SIZE],
  output logic                    busy
);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  localparam logic [_INDEX_WIDTH-1:0] LAST_SET  = _INDEX_WIDTH'(SET_COUNT - 1);
  localparam logic [TICK_WIDTH-1:0]   NOW_RESET = TICK_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0]   NOW_REBASE = TICK_WIDTH'(SET_SIZE + 1);

  logic [TICK_WIDTH-1:0]   ticks_reg [SET_COUNT][SET_SIZE];
  logic [TICK_WIDTH-1:0]   now_reg, now_next;
  logic [_INDEX_WIDTH-1:0] sidx_reg, sidx_next;
  state_t                  state_reg, state_next;

  logic                    wr_en;
  logic [TICK_WIDTH-1:0]   wr_val;
  logic                    sweep_en;
  logic [TICK_WIDTH-1:0]   sweep_row [SET_SIZE];
  logic [TICK_WIDTH-1:0]   rank      [SET_SIZE];

  // Rank of each way within the set being swept; zero ticks stay zero.
  for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_rank
    assign sweep_row[gi] = ticks_reg[sidx_reg][gi];

    always_comb begin
      logic [TICK_WIDTH-1:0] cnt;
      cnt = '0;
      for (int j = 0; j < SET_SIZE; j++) begin
        if (sweep_row[j] != '0 && sweep_row[j] < sweep_row[gi]) begin
          cnt = cnt + TICK_WIDTH'(1);
        end
      end
      rank[gi] = (sweep_row[gi] == '0) ? '0 : cnt + TICK_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_tick_out
    assign tick[gi+1] = ticks_reg[query_set][gi];
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg == SWEEP);

  always_comb begin
    state_next = state_reg;
    now_next   = now_reg;
    sidx_next  = sidx_reg;
    wr_en      = 1'b0;
    wr_val     = '0;
    sweep_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          wr_en = 1'b1;
          if (!req_invalidate) begin
            wr_val = now_reg;
            // A saturated counter is held and rebased by the sweep instead of wrapping.
            if (now_reg != '1) begin
              now_next = now_reg + TICK_WIDTH'(1);
            end else begin
              sidx_next  = '0;
              state_next = SWEEP;
            end
          end
        end
      end
      SWEEP: begin
        sweep_en = 1'b1;
        if (sidx_reg == LAST_SET) begin
          now_next   = NOW_REBASE;
          sidx_next  = '0;
          state_next = IDLE;
        end else begin
          sidx_next = sidx_reg + _INDEX_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      now_reg   <= NOW_RESET;
      sidx_reg  <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          ticks_reg[s][w] <= '0;
        end
      end
    end else begin
      state_reg <= state_next;
      now_reg   <= now_next;
      sidx_reg  <= sidx_next;
      if (wr_en) begin
        ticks_reg[req_set][req_way] <= wr_val;
      end
      if (sweep_en) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          ticks_reg[sidx_reg][w] <= rank[w];
        end
      end
    end
  end

endmodule

// File: tb/tb_lru_tick_tracker.sv
// Directed vector bench for lru_tick_tracker with 4-bit ticks, 4 sets, 4 ways.

module tb_lru_tick_tracker;

  localparam int NV = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_set;
  logic [1:0] req_way;
  logic       req_invalidate;
  logic [1:0] query_set;
  logic [3:0] tick [1:4];
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        inv;
    logic [1:0]  set;
    logic [1:0]  way;
    logic [1:0]  qset;
    logic [15:0] exp;   // way0 in [15:12] .. way3 in [3:0]
    logic        rdy;
    logic        bsy;
  } vec_t;

  vec_t vecs [0:NV-1];

  lru_tick_tracker #(
    .SET_COUNT (4),
    .SET_SIZE  (4),
    .TICK_WIDTH(4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_set       (req_set),
    .req_way       (req_way),
    .req_invalidate(req_invalidate),
    .query_set     (query_set),
    .tick          (tick),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ticks_packed();
    return {tick[1], tick[2], tick[3], tick[4]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic inv, input logic [1:0] s,
                         input logic [1:0] w, input logic [1:0] q, input logic [15:0] e,
                         input logic r, input logic b);
    vecs[i].v = v; vecs[i].inv = inv; vecs[i].set = s; vecs[i].way = w;
    vecs[i].qset = q; vecs[i].exp = e; vecs[i].rdy = r; vecs[i].bsy = b;
  endtask

  initial begin
    int cnt;

    //          idx v  inv set way q   expected  rdy bsy
    set_vec( 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0);
    set_vec( 1, 0, 0, 0, 0, 1, 16'h0000, 1, 0);
    set_vec( 2, 0, 0, 0, 0, 2, 16'h0000, 1, 0);
    set_vec( 3, 0, 0, 0, 0, 3, 16'h0000, 1, 0);
    set_vec( 4, 1, 0, 2, 0, 2, 16'h1000, 1, 0);
    set_vec( 5, 1, 0, 2, 1, 2, 16'h1200, 1, 0);
    set_vec( 6, 1, 0, 2, 2, 2, 16'h1230, 1, 0);
    set_vec( 7, 1, 1, 2, 1, 2, 16'h1030, 1, 0);
    set_vec( 8, 1, 0, 2, 3, 2, 16'h1034, 1, 0);
    set_vec( 9, 1, 0, 0, 0, 0, 16'h5000, 1, 0);
    set_vec(10, 1, 0, 0, 1, 0, 16'h5600, 1, 0);
    set_vec(11, 1, 0, 3, 0, 3, 16'h7000, 1, 0);
    set_vec(12, 1, 0, 3, 1, 3, 16'h7800, 1, 0);
    set_vec(13, 1, 0, 1, 2, 1, 16'h0090, 1, 0);
    set_vec(14, 1, 0, 0, 2, 0, 16'h56A0, 1, 0);
    set_vec(15, 1, 0, 3, 2, 3, 16'h78B0, 1, 0);
    set_vec(16, 1, 0, 1, 3, 1, 16'h009C, 1, 0);
    set_vec(17, 1, 0, 0, 3, 0, 16'h56AD, 1, 0);
    set_vec(18, 1, 0, 1, 0, 1, 16'hE09C, 1, 0);
    set_vec(19, 1, 0, 1, 0, 1, 16'hF09C, 0, 1);

    resetn = 1'b0; req_valid = 1'b0; req_set = '0; req_way = '0;
    req_invalidate = 1'b0; query_set = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_valid = vecs[i].v; req_invalidate = vecs[i].inv;
      req_set = vecs[i].set; req_way = vecs[i].way; query_set = vecs[i].qset;
      @(posedge clk);
      #1;
      $display("vec %0d v=%0d inv=%0d set=%0d way=%0d q=%0d tick=%h rdy=%0d busy=%0d",
               i, vecs[i].v, vecs[i].inv, vecs[i].set, vecs[i].way, vecs[i].qset,
               ticks_packed(), req_ready, busy);
      chk($sformatf("tick_v%0d", i), ticks_packed(), vecs[i].exp);
      chk($sformatf("ready_v%0d", i), {15'd0, req_ready}, {15'd0, vecs[i].rdy});
      chk($sformatf("busy_v%0d", i), {15'd0, busy}, {15'd0, vecs[i].bsy});
    end

    // Sweep with a stamp held pending on set 2 way 1.
    @(negedge clk);
    req_valid = 1'b1; req_invalidate = 1'b0; req_set = 2'd2; req_way = 2'd1; query_set = 2'd2;
    cnt = 0;
    while (busy && cnt < 20) begin
      chk("stall_ready", {15'd0, req_ready}, 16'd0);
      chk("stall_way1", {12'd0, tick[2]}, 16'd0);
      @(posedge clk);
      #1;
      cnt++;
    end
    $display("sweep lasted %0d cycles", cnt);
    chk("sweep_len", 16'(cnt), 16'd4);
    chk("post_sweep_ready", {15'd0, req_ready}, 16'd1);
    chk("pre_update_set2", ticks_packed(), 16'h1023);
    query_set = 2'd0; #1; chk("rank_set0", ticks_packed(), 16'h1234);
    query_set = 2'd1; #1; chk("rank_set1", ticks_packed(), 16'h3012);
    query_set = 2'd3; #1; chk("rank_set3", ticks_packed(), 16'h1230);
    query_set = 2'd2;
    @(posedge clk);
    #1;
    $display("stalled stamp accepted tick=%h", ticks_packed());
    chk("stalled_stamp", ticks_packed(), 16'h1523);

    // Drive now 6..15 into set 0 way 0, then reset during sweep cycle 2.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_set = 2'd0; req_way = 2'd0; query_set = 2'd0;
      @(posedge clk);
      #1;
      chk($sformatf("refill_%0d", k), {12'd0, tick[1]}, 16'(6 + k));
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("second_sweep_busy", {15'd0, busy}, 16'd1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    $display("mid-sweep reset busy=%0d ready=%0d", busy, req_ready);
    chk("midreset_busy", {15'd0, busy}, 16'd0);
    chk("midreset_ready", {15'd0, req_ready}, 16'd1);
    for (int q = 0; q < 4; q++) begin
      query_set = 2'(q);
      #1;
      chk($sformatf("midreset_set%0d", q), ticks_packed(), 16'h0000);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_set = 2'd1; req_way = 2'd2; query_set = 2'd1;
    @(posedge clk);
    #1;
    $display("first stamp after reset tick=%h", ticks_packed());
    chk("stamp_after_reset", ticks_packed(), 16'h0010);
    @(negedge clk);
    req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
